int_free_list_mp: RTL and testbench
===================================

Name: int_free_list_mp

Overview:
- Parametrised multi-port free list of integer physical-register tags for the rename stage.
- Successor to the single-port preloaded tag queue. Adds:
  - N allocate ports and M release ports per cycle.
  - All-or-nothing allocation grant.
  - Committed-head recovery on flush, so tags held by retired instructions survive a flush. A full reset-to-initial is still available through Clean.
- Sits between decode/rename (allocate), ROB commit (retire count) and the commit-side release of old mappings (free).

Parameters:
- TAGW, 6, tag width in bits.
- DEPTH, 32, number of free-list entries; power of two, ≥ 4.
- TAG_BASE, 32, first tag preloaded; entry i resets to TAG_BASE+i. Requires TAG_BASE+DEPTH ≤ 2^TAGW.
- ALLOC_PORTS, 2, allocate ports per cycle (1..4).
- FREE_PORTS, 2, release ports per cycle (1..4).
- PTRW, $clog2(DEPTH), index width. Pointers carry one extra wrap bit (PTRW+1 bits).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rest  in  1  synchronous reset, active-high.
- AllocReq  in  ALLOC_PORTS  per-port allocate request.
- AllocRdy  out  1  all requested ports can be served this cycle.
- AllocTag  out  ALLOC_PORTS*TAGW  tag for port i at bits [i*TAGW +: TAGW]; combinational.
- CmtNum  in  $clog2(ALLOC_PORTS+1)  number of oldest allocations retired this cycle.
- FreeVld  in  FREE_PORTS  per-port release valid.
- FreeTag  in  FREE_PORTS*TAGW  released tags, same packing as AllocTag.
- Flush  in  1  rollback of speculative allocations.
- Clean  in  1  reinitialise to the reset image.
- FreeCount  out  PTRW+1  free entries, 0..DEPTH.
- FlEmpty  out  1  FreeCount==0.
- FlFull  out  1  FreeCount==DEPTH.
- Overflow  out  1  sticky error: a release would exceed DEPTH.

Behaviour:
- State:
  - entry array [0:DEPTH-1] of TAGW bits;
  - Head (speculative alloc pointer), CmtHead (committed alloc pointer), Tail (release pointer), each PTRW+1 bits;
  - Overflow flag.
- Reset (Rest=1):
  - entry[i]=TAG_BASE+i; Head=CmtHead=0; Tail=DEPTH (wrap bit set, index 0).
  - Outputs: FreeCount=DEPTH, FlFull=1, FlEmpty=0, Overflow=0, AllocRdy=1.
  - AllocTag port i = TAG_BASE+i when all requested.
  - Rest overrides every other input, mid-operation included.
- FreeCount = Tail-Head, modulo 2^(PTRW+1).
- Alloc rank(i) = number of set AllocReq bits below i.
  - AllocTag[i] = entry[(Head+rank(i)) mod DEPTH], driven regardless of AllocReq.
- NA = popcount(AllocReq).
  - AllocRdy = (FreeCount ≥ NA) && !Flush && !Clean.
  - Uses the pre-edge count; same-cycle frees do not help.
- Allocation fires when AllocRdy && NA>0: Head += NA at the edge. No partial grants. When not ready, Head holds and the requester retries.
- Release:
  - Each FreeVld bit writes FreeTag[j] to entry[(Tail+frank(j)) mod DEPTH], where frank is the popcount of lower FreeVld bits. Tail += NF.
  - Overflow check: if FreeCount-NA_fired+NF > DEPTH, the whole release group is dropped (Tail and entries unchanged) and Overflow is set. It clears only on Rest or Clean.
- Commit: CmtHead += CmtNum every cycle. Bench assertion: CmtHead must not pass Head.
- Flush:
  - Head ← CmtHead+CmtNum (the new committed value).
  - Allocation is suppressed that cycle.
  - Releases and commit still apply normally.
- Clean: same image as reset except that it is input-driven. Beats Flush, alloc, free and commit in the same cycle.
- Priority, highest first: Rest > Clean > Flush > alloc. Release and commit are independent except as noted above.
- Wrap-around: all index arithmetic is mod DEPTH; the wrap bit distinguishes full from empty. Tags are never reordered.
- Simultaneous alloc and free when FreeCount==0: AllocRdy=0; the frees land; allocation is possible next cycle.
- Latency: a tag is visible on AllocTag the cycle after it is released.
- Tag width: FreeTag bits above TAGW are never stored.
- Implementation size: about 250 lines of RTL.

Test Plan:
- Reset, then AllocReq=2'b11 for 16 cycles → tags 32,33 … 62,63 in order. Then FlEmpty=1, AllocRdy=0, FreeCount=0.
- AllocReq=2'b10 after reset → AllocTag port1=32, Head=1. Next AllocReq=2'b11 → ports 33,34.
- Allocate 4 (32–35), CmtNum=1 twice, then Flush → Head=2, FreeCount=30. Next grant on port0=34.
- Drain to empty, FreeVld=2'b11 with tags 40,41 and AllocReq=1 in the same cycle → AllocRdy=0. Next cycle grants 40, then 41.
- From reset (full), FreeVld=1 with tag 5 → Overflow=1, FreeCount stays 32, Tail unchanged. Clean → Overflow=0.
- Run 3 full wrap cycles of random alloc/free/commit/flush against a reference model. FreeCount, AllocTag and order must match every cycle. Clean and Flush in the same cycle → reset image.

Source files
------------

// File: rtl/int_free_list_mp_if.sv
// Rename-side bundle for the multi-port physical-tag free list.
`timescale 1ns/1ps
interface int_free_list_mp_if #(
  parameter int TAGW        = 6,
  parameter int DEPTH       = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CMTW = $clog2(ALLOC_PORTS + 1);

  logic [ALLOC_PORTS-1:0]      AllocReq;
  logic                        AllocRdy;
  logic [ALLOC_PORTS*TAGW-1:0] AllocTag;
  logic [CMTW-1:0]             CmtNum;
  logic [FREE_PORTS-1:0]       FreeVld;
  logic [FREE_PORTS*TAGW-1:0]  FreeTag;
  logic                        Flush;
  logic                        Clean;
  logic [PTRW:0]               FreeCount;
  logic                        FlEmpty;
  logic                        FlFull;
  logic                        Overflow;

  modport master (
    output AllocReq, CmtNum, FreeVld, FreeTag, Flush, Clean,
    input  AllocRdy, AllocTag, FreeCount, FlEmpty, FlFull, Overflow
  );

  modport slave (
    input  AllocReq, CmtNum, FreeVld, FreeTag, Flush, Clean,
    output AllocRdy, AllocTag, FreeCount, FlEmpty, FlFull, Overflow
  );
endinterface

// File: rtl/int_free_list_mp.sv
// Multi-port circular free list of physical tags; AllocTag is combinational, a released tag
// is allocatable the next cycle; allocation is all-or-nothing, requesters retry while AllocRdy=0.
`timescale 1ns/1ps
module int_free_list_mp #(
  parameter int TAGW        = 6,
  parameter int DEPTH       = 32,
  parameter int TAG_BASE    = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int PTRW        = $clog2(DEPTH)
) (
  input logic              Clk,
  input logic              Rest,
  int_free_list_mp_if.slave fl
);

  logic [TAGW-1:0] r_mem [DEPTH];
  logic [PTRW:0]   r_head;
  logic [PTRW:0]   r_cmt_head;
  logic [PTRW:0]   r_tail;
  logic            r_overflow;

  logic [PTRW:0]   w_count;
  logic [PTRW:0]   w_na;
  logic [PTRW:0]   w_nf;
  logic [PTRW:0]   w_na_fired;
  logic [PTRW:0]   w_cmt_next;
  logic [PTRW-1:0] w_aidx [ALLOC_PORTS];
  logic [PTRW-1:0] w_fidx [FREE_PORTS];
  logic [PTRW+1:0] w_after_free;
  logic [ALLOC_PORTS*TAGW-1:0] w_alloc_tag;
  logic            w_alloc_rdy;
  logic            w_alloc_fire;
  logic            w_ovf;
  logic            w_free_ok;

  assign w_count    = r_tail - r_head;
  assign w_cmt_next = r_cmt_head + (PTRW+1)'(fl.CmtNum);

  // Each requesting port takes the next entry past those claimed by lower ports.
  always_comb begin
    w_na = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      w_aidx[i] = PTRW'(r_head + w_na);
      w_na      = w_na + (PTRW+1)'(fl.AllocReq[i]);
    end
  end

  always_comb begin
    w_nf = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      w_fidx[j] = PTRW'(r_tail + w_nf);
      w_nf      = w_nf + (PTRW+1)'(fl.FreeVld[j]);
    end
  end

  always_comb begin
    w_alloc_tag = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      w_alloc_tag[i*TAGW +: TAGW] = r_mem[w_aidx[i]];
    end
  end

  // Readiness uses the pre-edge count, so same-cycle releases cannot rescue an allocation.
  assign w_alloc_rdy  = (w_count >= w_na) && !fl.Flush && !fl.Clean;
  assign w_alloc_fire = w_alloc_rdy && (w_na != '0);
  assign w_na_fired   = w_alloc_fire ? w_na : '0;

  assign w_after_free = {1'b0, w_count} - {1'b0, w_na_fired} + {1'b0, w_nf};
  assign w_ovf        = w_after_free > (PTRW+2)'(DEPTH);
  assign w_free_ok    = (w_nf != '0) && !w_ovf;

  always_ff @(posedge Clk) begin
    if (Rest || fl.Clean) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAGW'(TAG_BASE + i);
      end
      r_head     <= '0;
      r_cmt_head <= '0;
      r_tail     <= (PTRW+1)'(DEPTH);
      r_overflow <= 1'b0;
    end else begin
      r_cmt_head <= w_cmt_next;
      // Flush rewinds to the committed point including this cycle's retirements.
      if (fl.Flush) begin
        r_head <= w_cmt_next;
      end else if (w_alloc_fire) begin
        r_head <= r_head + w_na;
      end
      if (w_free_ok) begin
        for (int j = 0; j < FREE_PORTS; j++) begin
          if (fl.FreeVld[j]) begin
            r_mem[w_fidx[j]] <= fl.FreeTag[j*TAGW +: TAGW];
          end
        end
        r_tail <= r_tail + w_nf;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign fl.AllocRdy  = w_alloc_rdy;
  assign fl.AllocTag  = w_alloc_tag;
  assign fl.FreeCount = w_count;
  assign fl.FlEmpty   = (w_count == '0);
  assign fl.FlFull    = (w_count == (PTRW+1)'(DEPTH));
  assign fl.Overflow  = r_overflow;

endmodule

// File: tb/tb_int_free_list_mp.sv
// Scenario bench for int_free_list_mp with a queue scoreboard and a random reference model.
`timescale 1ns/1ps
module tb_int_free_list_mp;
  localparam int TAGW = 6;
  localparam int DEPTH = 32;
  localparam int TAG_BASE = 32;
  localparam int AP = 2;
  localparam int FP = 2;

  logic Clk = 1'b0;
  logic Rest = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 Clk = ~Clk;

  int_free_list_mp_if #(.TAGW(TAGW), .DEPTH(DEPTH), .ALLOC_PORTS(AP), .FREE_PORTS(FP)) fl ();

  int_free_list_mp #(.TAGW(TAGW), .DEPTH(DEPTH), .TAG_BASE(TAG_BASE),
                     .ALLOC_PORTS(AP), .FREE_PORTS(FP)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .fl   (fl)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    fl.AllocReq = '0;
    fl.CmtNum   = '0;
    fl.FreeVld  = '0;
    fl.FreeTag  = '0;
    fl.Flush    = 1'b0;
    fl.Clean    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Rest = 1'b1;
    tick();
    tick();
    Rest = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    Rest = 1'b1;
    tick();
    fl.AllocReq = 2'b11;
    fl.FreeVld  = 2'b01;
    fl.FreeTag  = {6'd9, 6'd7};
    tick();
    idle();
    Rest = 1'b0;
    @(negedge Clk);
    checks++; if (fl.FreeCount !== 6'd32) begin errors++; $display("FAIL reset_count got=%0d exp=32", fl.FreeCount); end
    checks++; if (fl.FlFull !== 1'b1) begin errors++; $display("FAIL reset_full got=%b exp=1", fl.FlFull); end
    checks++; if (fl.FlEmpty !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b exp=0", fl.FlEmpty); end
    checks++; if (fl.Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", fl.Overflow); end
    checks++; if (fl.AllocRdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", fl.AllocRdy); end
    fl.AllocReq = 2'b11;
    #1;
    checks++; if (fl.AllocTag !== {6'd33, 6'd32}) begin errors++; $display("FAIL reset_tags got=%h exp=%h", fl.AllocTag, {6'd33, 6'd32}); end
    fl.AllocReq = 2'b00;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      fl.AllocReq = 2'b11;
      exp_q.push_back(TAG_BASE + 2*k);
      exp_q.push_back(TAG_BASE + 2*k + 1);
      @(negedge Clk);
      checks++;
      if (fl.AllocRdy !== 1'b1) begin
        errors++; $display("FAIL drain_rdy cyc=%0d got=%b exp=1", k, fl.AllocRdy);
      end else begin
        for (int p = 0; p < AP; p++) begin
          int e;
          e = exp_q.pop_front();
          checks++;
          if (fl.AllocTag[p*TAGW +: TAGW] !== 6'(e)) begin
            errors++; $display("FAIL drain_tag cyc=%0d port=%0d got=%0d exp=%0d", k, p, fl.AllocTag[p*TAGW +: TAGW], e);
          end
        end
      end
      tick();
    end
    exp_q.delete();
    fl.AllocReq = 2'b11;
    @(negedge Clk);
    checks++; if (fl.FlEmpty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", fl.FlEmpty); end
    checks++; if (fl.AllocRdy !== 1'b0) begin errors++; $display("FAIL drain_rdy_end got=%b exp=0", fl.AllocRdy); end
    checks++; if (fl.FreeCount !== 6'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", fl.FreeCount); end
    fl.AllocReq = 2'b00;
    tick();
  endtask

  task automatic test_partial();
    do_reset();
    fl.AllocReq = 2'b10;
    @(negedge Clk);
    checks++; if (fl.AllocTag[TAGW +: TAGW] !== 6'd32) begin errors++; $display("FAIL partial_p1 got=%0d exp=32", fl.AllocTag[TAGW +: TAGW]); end
    tick();
    fl.AllocReq = 2'b11;
    @(negedge Clk);
    checks++; if (dut.r_head !== 6'd1) begin errors++; $display("FAIL partial_head got=%0d exp=1", dut.r_head); end
    checks++; if (fl.AllocTag !== {6'd34, 6'd33}) begin errors++; $display("FAIL partial_tags got=%h exp=%h", fl.AllocTag, {6'd34, 6'd33}); end
    fl.AllocReq = 2'b00;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    fl.AllocReq = 2'b11;
    tick();
    tick();
    fl.AllocReq = 2'b00;
    fl.CmtNum = 2'd1;
    tick();
    tick();
    fl.CmtNum = 2'd0;
    fl.Flush = 1'b1;
    fl.AllocReq = 2'b01;
    @(negedge Clk);
    checks++; if (fl.AllocRdy !== 1'b0) begin errors++; $display("FAIL flush_rdy got=%b exp=0", fl.AllocRdy); end
    checks++; if (fl.FreeCount !== 6'd28) begin errors++; $display("FAIL flush_pre_count got=%0d exp=28", fl.FreeCount); end
    tick();
    fl.Flush = 1'b0;
    @(negedge Clk);
    checks++; if (dut.r_head !== 6'd2) begin errors++; $display("FAIL flush_head got=%0d exp=2", dut.r_head); end
    checks++; if (fl.FreeCount !== 6'd30) begin errors++; $display("FAIL flush_count got=%0d exp=30", fl.FreeCount); end
    checks++; if (fl.AllocTag[0 +: TAGW] !== 6'd34) begin errors++; $display("FAIL flush_tag got=%0d exp=34", fl.AllocTag[0 +: TAGW]); end
    fl.AllocReq = 2'b00;
    tick();
  endtask

  task automatic test_empty_free();
    do_reset();
    fl.AllocReq = 2'b11;
    for (int k = 0; k < 16; k++) tick();
    fl.AllocReq = 2'b01;
    fl.FreeVld = 2'b11;
    fl.FreeTag = {6'd41, 6'd40};
    @(negedge Clk);
    checks++; if (fl.AllocRdy !== 1'b0) begin errors++; $display("FAIL empfree_rdy got=%b exp=0", fl.AllocRdy); end
    tick();
    fl.FreeVld = 2'b00;
    fl.FreeTag = '0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(40 + k);
      @(negedge Clk);
      checks++;
      if (fl.AllocRdy !== 1'b1) begin
        errors++; $display("FAIL empfree_grant k=%0d got=%b exp=1", k, fl.AllocRdy);
        exp_q.delete();
      end else begin
        int e;
        e = exp_q.pop_front();
        checks++;
        if (fl.AllocTag[0 +: TAGW] !== 6'(e)) begin errors++; $display("FAIL empfree_tag k=%0d got=%0d exp=%0d", k, fl.AllocTag[0 +: TAGW], e); end
      end
      tick();
    end
    fl.AllocReq = 2'b00;
    @(negedge Clk);
    checks++; if (fl.FlEmpty !== 1'b1) begin errors++; $display("FAIL empfree_empty got=%b exp=1", fl.FlEmpty); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    fl.FreeVld = 2'b01;
    fl.FreeTag = {6'd0, 6'd5};
    tick();
    idle();
    @(negedge Clk);
    checks++; if (fl.Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", fl.Overflow); end
    checks++; if (fl.FreeCount !== 6'd32) begin errors++; $display("FAIL ovf_count got=%0d exp=32", fl.FreeCount); end
    checks++; if (dut.r_tail !== 6'd32) begin errors++; $display("FAIL ovf_tail got=%0d exp=32", dut.r_tail); end
    checks++; if (dut.r_mem[0] !== 6'd32) begin errors++; $display("FAIL ovf_entry got=%0d exp=32", dut.r_mem[0]); end
    tick();
    @(negedge Clk);
    checks++; if (fl.Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", fl.Overflow); end
    fl.Clean = 1'b1;
    tick();
    fl.Clean = 1'b0;
    @(negedge Clk);
    checks++; if (fl.Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clean got=%b exp=0", fl.Overflow); end
    // A same-cycle grant makes room for a release from the full state.
    fl.AllocReq = 2'b01;
    fl.FreeVld = 2'b01;
    fl.FreeTag = {6'd0, 6'd50};
    tick();
    idle();
    @(negedge Clk);
    checks++; if (fl.Overflow !== 1'b0) begin errors++; $display("FAIL ovf_room got=%b exp=0", fl.Overflow); end
    checks++; if (fl.FreeCount !== 6'd32) begin errors++; $display("FAIL ovf_room_count got=%0d exp=32", fl.FreeCount); end
    tick();
  endtask

  task automatic test_clean_flush();
    do_reset();
    fl.AllocReq = 2'b11;
    tick(); tick(); tick();
    fl.Clean = 1'b1;
    fl.Flush = 1'b1;
    fl.CmtNum = 2'd1;
    fl.FreeVld = 2'b01;
    fl.FreeTag = {6'd0, 6'd7};
    @(negedge Clk);
    checks++; if (fl.AllocRdy !== 1'b0) begin errors++; $display("FAIL cf_rdy got=%b exp=0", fl.AllocRdy); end
    tick();
    idle();
    @(negedge Clk);
    checks++; if (fl.FreeCount !== 6'd32) begin errors++; $display("FAIL cf_count got=%0d exp=32", fl.FreeCount); end
    checks++; if (dut.r_head !== 6'd0 || dut.r_cmt_head !== 6'd0 || dut.r_tail !== 6'd32) begin
      errors++; $display("FAIL cf_ptrs got=%0d/%0d/%0d exp=0/0/32", dut.r_head, dut.r_cmt_head, dut.r_tail);
    end
    fl.AllocReq = 2'b11;
    #1;
    checks++; if (fl.AllocTag !== {6'd33, 6'd32}) begin errors++; $display("FAIL cf_tags got=%h exp=%h", fl.AllocTag, {6'd33, 6'd32}); end
    fl.AllocReq = 2'b00;
    tick();
  endtask

  task automatic test_random();
    int m_mem [DEPTH];
    int m_head, m_cmt, m_tail;
    int spec_q[$];
    int own_q[$];
    int grant_q[$];
    do_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = TAG_BASE + i;
    m_head = 0; m_cmt = 0; m_tail = DEPTH;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [1:0] req, fv;
      logic [5:0] ft [2];
      logic flush, clean;
      int cmt, nf, na, cnt, rank, sel, maxc, maxf;
      logic [5:0] d;
      bit rdy, fire;
      req   = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
      clean = ($urandom_range(0, 299) == 0);
      maxc  = (spec_q.size() < AP) ? spec_q.size() : AP;
      cmt   = $urandom_range(0, maxc);
      maxf  = (own_q.size() < FP) ? own_q.size() : FP;
      nf    = $urandom_range(0, maxf);
      fv    = (nf == 2) ? 2'b11 : (nf == 1) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00;
      for (int j = 0; j < FP; j++) begin
        ft[j] = 6'd0;
        if (fv[j]) begin
          sel = $urandom_range(0, own_q.size() - 1);
          ft[j] = 6'(own_q[sel]);
          own_q.delete(sel);
        end
      end
      fl.AllocReq = req; fl.CmtNum = 2'(cmt); fl.Flush = flush; fl.Clean = clean;
      fl.FreeVld = fv; fl.FreeTag = {ft[1], ft[0]};
      cnt  = m_tail - m_head;
      na   = int'(req[0]) + int'(req[1]);
      rdy  = (cnt >= na) && !flush && !clean;
      fire = rdy && (na > 0);
      grant_q.delete();
      if (fire) begin
        rank = 0;
        for (int p = 0; p < AP; p++) if (req[p]) begin
          exp_q.push_back(m_mem[(m_head + rank) % DEPTH]);
          grant_q.push_back(m_mem[(m_head + rank) % DEPTH]);
          rank++;
        end
      end
      @(negedge Clk);
      checks++; if (fl.AllocRdy !== rdy) begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, fl.AllocRdy, rdy); end
      checks++; if (fl.FreeCount !== 6'(cnt)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, fl.FreeCount, cnt); end
      checks++; if (fl.FlEmpty !== (cnt == 0) || fl.FlFull !== (cnt == DEPTH)) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", cyc, fl.FlEmpty, fl.FlFull, cnt == 0, cnt == DEPTH);
      end
      checks++; if (fl.Overflow !== 1'b0) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=0", cyc, fl.Overflow); end
      d = dut.r_head - dut.r_cmt_head;
      checks++; if (d > 6'd32) begin errors++; $display("FAIL rnd_cmt_passed_head cyc=%0d got_gap=%0d exp<=32", cyc, d); end
      if (fl.AllocRdy === 1'b1) begin
        for (int p = 0; p < AP; p++) if (req[p] && exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          checks++;
          if (fl.AllocTag[p*TAGW +: TAGW] !== 6'(e)) begin
            errors++; $display("FAIL rnd_tag cyc=%0d port=%0d got=%0d exp=%0d", cyc, p, fl.AllocTag[p*TAGW +: TAGW], e);
          end
        end
      end
      exp_q.delete();
      if (clean) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = TAG_BASE + i;
        m_head = 0; m_cmt = 0; m_tail = DEPTH;
        spec_q.delete(); own_q.delete();
      end else begin
        for (int c = 0; c < cmt; c++) own_q.push_back(spec_q.pop_front());
        foreach (grant_q[g]) spec_q.push_back(grant_q[g]);
        m_cmt += cmt;
        if (flush) begin
          m_head = m_cmt;
          spec_q.delete();
        end else if (fire) begin
          m_head += na;
        end
        rank = 0;
        for (int j = 0; j < FP; j++) if (fv[j]) begin
          m_mem[(m_tail + rank) % DEPTH] = int'(ft[j]);
          rank++;
        end
        m_tail += nf;
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_drain();
    test_partial();
    test_flush();
    test_empty_free();
    test_overflow();
    test_clean_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time_limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
